// File: rtl/wb_slave_mem_pkg.sv
// Shared constants and types for the Wishbone slave memory model.
// Cycle/burst type encodings and the slave FSM state enum.
package wb_slave_mem_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_BURST
    } state_e;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next word index for a Wishbone incrementing burst.
// Wrap modes keep the upper bits and roll the low log2(N) bits.
module wb_burst_addr_gen
    import wb_slave_mem_pkg::*;
#(
    parameter int IW = 32
) (
    input  logic [IW-1:0] idx,
    input  logic [1:0]    bte,
    output logic [IW-1:0] nxt
);

    logic [IW-1:0] mask;
    logic [IW-1:0] inc;

    always_comb begin
        mask = '1;
        unique case (bte)
            BTE_LINEAR: mask = '1;
            BTE_WRAP4:  mask = IW'(3);
            BTE_WRAP8:  mask = IW'(7);
            BTE_WRAP16: mask = IW'(15);
            default:    mask = '1;
        endcase
    end

    assign inc = idx + IW'(1);
    assign nxt = (idx & ~mask) | (inc & mask);

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B4 slave memory with programmable wait states,
// classic and incrementing-burst cycles, ACK/ERR termination.
module wb_slave_mem #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic                       WE,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    output logic                       ACK,
    output logic                       ERR,
    input  logic [3:0]                 wait_cycles,
    output logic [31:0]                beat_count
);

    import wb_slave_mem_pkg::*;

    localparam int AW    = WB_ADDR_WIDTH;
    localparam int DW    = WB_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int LSB   = $clog2(SW);
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int MW    = MEM_DEPTH_LOG2;

    logic [DW-1:0] mem [DEPTH];

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [2:0]    cti_q, cti_d;
    logic [1:0]    bte_q, bte_d;
    logic          oor_q, oor_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [31:0]   cnt_q, cnt_d;

    logic [AW-1:0] off;
    logic [AW-1:0] adr_idx;
    logic          adr_oor;
    logic [AW-1:0] nxt_idx;
    logic          nxt_oor;
    logic [DW-1:0] rd_adr, rd_cur, rd_nxt;
    logic          adv;
    logic          beat;
    logic          mem_we;
    logic [SW-1:0] wsel;

    assign off     = ADR - BASE_ADDR;
    assign adr_idx = off >> LSB;
    assign adr_oor = (ADR < BASE_ADDR) || ((adr_idx >> MW) != '0);

    wb_burst_addr_gen #(
        .IW(AW)
    ) u_addr_gen (
        .idx(idx_q),
        .bte(bte_q),
        .nxt(nxt_idx)
    );

    assign nxt_oor = (nxt_idx >> MW) != '0;

    assign rd_adr = mem[adr_idx[MW-1:0]];
    assign rd_cur = mem[idx_q[MW-1:0]];
    assign rd_nxt = mem[nxt_idx[MW-1:0]];

    assign beat = (ack_q | err_q) & STB & CYC;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        sel_d   = sel_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        oor_d   = oor_q;
        wcnt_d  = wcnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        cnt_d   = beat ? cnt_q + 32'd1 : cnt_q;
        adv     = 1'b0;
        if (!CYC) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (STB) begin
                        idx_d  = adr_idx;
                        we_d   = WE;
                        sel_d  = SEL;
                        cti_d  = CTI;
                        bte_d  = BTE;
                        oor_d  = adr_oor;
                        wcnt_d = wait_cycles;
                        if (wait_cycles == 4'd0) begin
                            state_d = S_BEAT;
                            ack_d   = !adr_oor;
                            err_d   = adr_oor;
                            dat_d   = adr_oor ? '0 : rd_adr;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt_q <= 4'd1) begin
                        wcnt_d  = '0;
                        state_d = S_BEAT;
                        ack_d   = !oor_q;
                        err_d   = oor_q;
                        dat_d   = oor_q ? '0 : rd_cur;
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
                S_BEAT: begin
                    if (cti_q == CTI_INCR && !err_q) begin
                        state_d = S_BURST;
                        adv     = STB;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BURST: begin
                    if (ack_q && STB) begin
                        if (CTI == CTI_EOB) begin
                            state_d = S_IDLE;
                        end else begin
                            adv = 1'b1;
                        end
                    end else if (STB) begin
                        ack_d = 1'b1;
                        dat_d = rd_cur;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // A burst stepping past the window ends with one ERR beat.
            if (adv) begin
                idx_d = nxt_idx;
                if (nxt_oor) begin
                    state_d = S_BEAT;
                    err_d   = 1'b1;
                    dat_d   = '0;
                end else begin
                    ack_d = 1'b1;
                    dat_d = rd_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            cti_q   <= CTI_CLASSIC;
            bte_q   <= BTE_LINEAR;
            oor_q   <= 1'b0;
            wcnt_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            oor_q   <= oor_d;
            wcnt_q  <= wcnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_we = ack_q & STB & CYC & we_q;
    assign wsel   = (state_q == S_BEAT) ? sel_q : SEL;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < SW; b++) begin
                if (wsel[b]) begin
                    mem[idx_q[MW-1:0]][b*8 +: 8] <= DAT_W[b*8 +: 8];
                end
            end
        end
    end

    assign ACK        = ack_q;
    assign ERR        = err_q;
    assign DAT_R      = dat_q;
    assign beat_count = cnt_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed self-checking bench for wb_slave_mem.
// Each task drives one scenario and checks its own results.
module tb_wb_slave_mem;

    logic        clk;
    logic        rstn;
    logic [31:0] ADR;
    logic [31:0] DAT_W;
    logic [31:0] DAT_R;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [3:0]  SEL;
    logic [2:0]  CTI;
    logic [1:0]  BTE;
    logic        ACK;
    logic        ERR;
    logic [3:0]  wait_cycles;
    logic [31:0] beat_count;

    int checks;
    int failures;

    wb_slave_mem dut (
        .clk(clk),
        .rstn(rstn),
        .ADR(ADR),
        .DAT_W(DAT_W),
        .DAT_R(DAT_R),
        .CYC(CYC),
        .STB(STB),
        .WE(WE),
        .SEL(SEL),
        .CTI(CTI),
        .BTE(BTE),
        .ACK(ACK),
        .ERR(ERR),
        .wait_cycles(wait_cycles),
        .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        CYC = 1'b0;
        STB = 1'b0;
        WE  = 1'b0;
        CTI = 3'b000;
        BTE = 2'b00;
    endtask

    task automatic do_classic(
        input  logic [31:0] adr,
        input  logic        we,
        input  logic [31:0] dat,
        input  logic [3:0]  sel,
        input  logic [3:0]  wc,
        output logic        got_ack,
        output logic        got_err,
        output logic [31:0] rdat,
        output int          lat,
        output logic        after
    );
        CYC = 1'b1;
        STB = 1'b1;
        WE = we;
        ADR = adr;
        DAT_W = dat;
        SEL = sel;
        CTI = 3'b000;
        BTE = 2'b00;
        wait_cycles = wc;
        lat = 0;
        while (!(ACK || ERR) && lat < 40) begin
            step();
            lat++;
        end
        if (!(ACK || ERR)) lat = -1;
        got_ack = ACK;
        got_err = ERR;
        rdat = DAT_R;
        step();
        after = ACK | ERR;
        bus_idle();
        step();
    endtask

    task automatic test_reset();
        bus_idle();
        ADR = '0;
        DAT_W = '0;
        SEL = '0;
        wait_cycles = '0;
        rstn = 1'b0;
        step();
        step();
        checks++;
        if (ACK !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack: got %b want 0", ACK);
        end
        checks++;
        if (ERR !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: got %b want 0", ERR);
        end
        checks++;
        if (DAT_R !== 32'h0) begin
            failures++;
            $display("FAIL reset_dat: got %h want 0", DAT_R);
        end
        checks++;
        if (beat_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d want 0", beat_count);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_classic();
        logic a, e, af;
        logic [31:0] d;
        int lat;
        do_classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 4'd0, a, e, d, lat, af);
        checks++;
        if (lat != 1 || a !== 1'b1 || af !== 1'b0) begin
            failures++;
            $display("FAIL classic_wr: lat=%0d ack=%b after=%b want 1 1 0",
                     lat, a, af);
        end
        do_classic(32'h10, 1'b0, 32'h0, 4'hF, 4'd0, a, e, d, lat, af);
        checks++;
        if (lat != 1 || a !== 1'b1 || af !== 1'b0) begin
            failures++;
            $display("FAIL classic_rd: lat=%0d ack=%b after=%b want 1 1 0",
                     lat, a, af);
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL classic_rd_dat: got %h want deadbeef", d);
        end
        checks++;
        if (beat_count !== 32'd2) begin
            failures++;
            $display("FAIL classic_cnt: got %0d want 2", beat_count);
        end
    endtask

    task automatic test_byte_lane();
        logic a, e, af;
        logic [31:0] d;
        int lat;
        do_classic(32'h20, 1'b1, 32'h11223344, 4'hF, 4'd0, a, e, d, lat, af);
        do_classic(32'h20, 1'b1, 32'h000000AA, 4'b0001, 4'd0, a, e, d, lat, af);
        do_classic(32'h20, 1'b0, 32'h0, 4'hF, 4'd0, a, e, d, lat, af);
        checks++;
        if (d !== 32'h112233AA) begin
            failures++;
            $display("FAIL byte_lane: got %h want 112233aa", d);
        end
    endtask

    task automatic test_wait();
        logic a, e, af;
        logic [31:0] d;
        int lat;
        do_classic(32'h30, 1'b1, 32'hCAFE0001, 4'hF, 4'd0, a, e, d, lat, af);
        do_classic(32'h30, 1'b0, 32'h0, 4'hF, 4'd3, a, e, d, lat, af);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL wait3_lat: got %0d want 4", lat);
        end
        checks++;
        if (a !== 1'b1 || af !== 1'b0) begin
            failures++;
            $display("FAIL wait3_ack: ack=%b after=%b want 1 0", a, af);
        end
        checks++;
        if (d !== 32'hCAFE0001) begin
            failures++;
            $display("FAIL wait3_dat: got %h want cafe0001", d);
        end
    endtask

    task automatic test_wrap4();
        logic a, e, af;
        logic [31:0] d;
        int lat;
        logic [31:0] exp_dat [4];
        exp_dat[0] = 32'd2;
        exp_dat[1] = 32'd3;
        exp_dat[2] = 32'd0;
        exp_dat[3] = 32'd1;
        for (int i = 0; i < 4; i++) begin
            do_classic(32'(i * 4), 1'b1, 32'(i), 4'hF, 4'd0,
                       a, e, d, lat, af);
        end
        CYC = 1'b1;
        STB = 1'b1;
        WE = 1'b0;
        ADR = 32'h8;
        CTI = 3'b010;
        BTE = 2'b01;
        wait_cycles = 4'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ACK !== 1'b1 || DAT_R !== exp_dat[i]) begin
                failures++;
                $display("FAIL wrap4_beat%0d: ack=%b dat=%h want 1 %h",
                         i, ACK, DAT_R, exp_dat[i]);
            end
            if (i == 3) CTI = 3'b111;
        end
        step();
        checks++;
        if (ACK !== 1'b0 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL wrap4_end: ack=%b err=%b want 0 0", ACK, ERR);
        end
        bus_idle();
        step();
        checks++;
        if (beat_count !== 32'd15) begin
            failures++;
            $display("FAIL wrap4_cnt: got %0d want 15", beat_count);
        end
    endtask

    task automatic test_err();
        logic a, e, af;
        logic [31:0] d;
        int lat;
        do_classic(32'h1000, 1'b0, 32'h0, 4'hF, 4'd0, a, e, d, lat, af);
        checks++;
        if (lat != 1 || e !== 1'b1 || a !== 1'b0 || af !== 1'b0) begin
            failures++;
            $display("FAIL oor_rd: lat=%0d err=%b ack=%b after=%b want 1 1 0 0",
                     lat, e, a, af);
        end
        do_classic(32'h1000, 1'b1, 32'h55555555, 4'hF, 4'd0,
                   a, e, d, lat, af);
        checks++;
        if (e !== 1'b1 || a !== 1'b0) begin
            failures++;
            $display("FAIL oor_wr: err=%b ack=%b want 1 0", e, a);
        end
        do_classic(32'h0, 1'b0, 32'h0, 4'hF, 4'd0, a, e, d, lat, af);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL oor_wr_nowrite: got %h want 0", d);
        end
        checks++;
        if (beat_count !== 32'd18) begin
            failures++;
            $display("FAIL oor_cnt: got %0d want 18", beat_count);
        end
    endtask

    task automatic test_cyc_drop();
        logic a, e, af;
        logic [31:0] d;
        int lat;
        int seen;
        CYC = 1'b1;
        STB = 1'b1;
        WE = 1'b0;
        ADR = 32'h10;
        CTI = 3'b000;
        wait_cycles = 4'd5;
        step();
        step();
        step();
        bus_idle();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ACK || ERR) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL cyc_drop: term cycles=%0d want 0", seen);
        end
        do_classic(32'h10, 1'b0, 32'h0, 4'hF, 4'd0, a, e, d, lat, af);
        checks++;
        if (lat != 1 || a !== 1'b1 || d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL cyc_drop_next: lat=%0d ack=%b dat=%h want 1 1 deadbeef",
                     lat, a, d);
        end
    endtask

    task automatic test_burst_oob();
        logic a, e, af;
        logic [31:0] d;
        int lat;
        do_classic(32'hFFC, 1'b1, 32'h77, 4'hF, 4'd0, a, e, d, lat, af);
        CYC = 1'b1;
        STB = 1'b1;
        WE = 1'b0;
        ADR = 32'hFFC;
        CTI = 3'b010;
        BTE = 2'b00;
        wait_cycles = 4'd0;
        step();
        checks++;
        if (ACK !== 1'b1 || DAT_R !== 32'h77) begin
            failures++;
            $display("FAIL oob_beat0: ack=%b dat=%h want 1 77", ACK, DAT_R);
        end
        step();
        checks++;
        if (ERR !== 1'b1 || ACK !== 1'b0) begin
            failures++;
            $display("FAIL oob_beat1: err=%b ack=%b want 1 0", ERR, ACK);
        end
        step();
        bus_idle();
        checks++;
        if (ERR !== 1'b0 || ACK !== 1'b0) begin
            failures++;
            $display("FAIL oob_end: err=%b ack=%b want 0 0", ERR, ACK);
        end
        step();
        checks++;
        if (beat_count !== 32'd22) begin
            failures++;
            $display("FAIL oob_cnt: got %0d want 22", beat_count);
        end
    endtask

    task automatic test_reset_mid();
        logic a, e, af;
        logic [31:0] d;
        int lat;
        int seen;
        CYC = 1'b1;
        STB = 1'b1;
        WE = 1'b0;
        ADR = 32'h8;
        CTI = 3'b010;
        BTE = 2'b01;
        wait_cycles = 4'd0;
        step();
        step();
        rstn = 1'b0;
        #1;
        checks++;
        if (ACK !== 1'b0 || DAT_R !== 32'h0 || beat_count !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid: ack=%b dat=%h cnt=%0d want 0 0 0",
                     ACK, DAT_R, beat_count);
        end
        bus_idle();
        step();
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ACK || ERR) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_mid_quiet: term cycles=%0d want 0", seen);
        end
        do_classic(32'h4, 1'b0, 32'h0, 4'hF, 4'd0, a, e, d, lat, af);
        checks++;
        if (lat != 1 || a !== 1'b1 || d !== 32'h1) begin
            failures++;
            $display("FAIL rst_mid_next: lat=%0d ack=%b dat=%h want 1 1 1",
                     lat, a, d);
        end
        do_classic(32'h40, 1'b1, 32'h12345678, 4'hF, 4'd0,
                   a, e, d, lat, af);
        CYC = 1'b1;
        STB = 1'b1;
        WE = 1'b1;
        ADR = 32'h40;
        DAT_W = 32'h99;
        SEL = 4'hF;
        CTI = 3'b000;
        step();
        rstn = 1'b0;
        step();
        bus_idle();
        rstn = 1'b1;
        step();
        do_classic(32'h40, 1'b0, 32'h0, 4'hF, 4'd0, a, e, d, lat, af);
        checks++;
        if (d !== 32'h12345678) begin
            failures++;
            $display("FAIL rst_wr_discard: got %h want 12345678", d);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        test_reset();
        test_classic();
        test_byte_lane();
        test_wait();
        test_wrap4();
        test_err();
        test_cyc_drop();
        test_burst_oob();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_slave_mem.md
Name: wb_slave_mem

Overview:
- Wishbone B4 slave memory model that sits directly downstream of the team's Wishbone master BFM on a shared wb_if.
- Consumes the master's classic and incrementing-burst cycles and returns ACK/ERR and read data.
- Wait states are programmable, so benches can stress the master's handshake timing.
- Synthesizable-style RTL; memory contents are not reset.

Parameters:
- WB_ADDR_WIDTH, 32, byte address width.
- WB_DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64.
- MEM_DEPTH_LOG2, 10, log2 of memory depth in words.
- BASE_ADDR, 0, byte base address of the memory window; aligned to the window size.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- ADR  in  WB_ADDR_WIDTH  byte address.
- DAT_W  in  WB_DATA_WIDTH  write data.
- DAT_R  out  WB_DATA_WIDTH  read data.
- CYC  in  1  bus cycle.
- STB  in  1  strobe.
- WE  in  1  write enable.
- SEL  in  WB_DATA_WIDTH/8  byte lane selects.
- CTI  in  3  cycle type: 000 classic, 010 incrementing, 111 end of burst.
- BTE  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- ACK  out  1  normal termination.
- ERR  out  1  error termination.
- wait_cycles  in  4  wait states before the first beat; sampled when a cycle starts.
- beat_count  out  32  total terminated beats (ACK or ERR); wraps modulo 2^32.

Behaviour:
- Interface: one clock (clk); reset rstn is asynchronous, active-low.
- Reset values: ACK=0, ERR=0, DAT_R=0, beat_count=0, state=IDLE, wait counter=0. Memory array is untouched.
- Decode:
  - Word index = (ADR-BASE_ADDR) >> log2(WB_DATA_WIDTH/8).
  - Out of range when ADR < BASE_ADDR or index >= 2^MEM_DEPTH_LOG2.
  - Low address bits are ignored.
- States: IDLE, WAIT, BEAT, BURST.
- IDLE:
  - On CYC&STB, latch address, WE, SEL, CTI, BTE and wait counter = wait_cycles.
  - If wait_cycles=0, go to BEAT; otherwise go to WAIT.
- WAIT: decrement each cycle; at 1, go to BEAT. CYC=0 at any point goes to IDLE.
- BEAT (one cycle):
  - Out of range: drive ERR=1. Otherwise drive ACK=1, with DAT_R = mem[index] registered on entry. Writes are ignored on ERR.
  - Minimum latency: STB sampled at edge N gives ACK high during cycle N+1.
  - Write commits at the edge closing the ACK cycle, per SEL lane.
  - Exit: if the latched CTI=010 and the beat is not ERR, go to BURST; otherwise go to IDLE with ACK/ERR=0.
- BURST:
  - ACK held high every cycle while CYC&STB.
  - At each edge with ACK&STB, the address advances per BTE wrap (wrap-N keeps the upper bits and increments the low log2(N) word bits; linear increments) and DAT_R loads the next word.
  - If CTI=111 at that edge, this is the final beat; next state is IDLE with ACK=0.
  - If STB=0 while CYC=1, ACK drops and no address advance occurs; resume when STB returns.
  - If the burst crosses out of range, that beat returns ERR and the FSM goes to IDLE.
- Simultaneous events:
  - CYC drop overrides everything: go to IDLE next edge, ACK/ERR=0 next cycle, no write at that edge.
  - ACK and ERR are never both high.
- beat_count increments at each edge where (ACK|ERR)&STB&CYC.
- Reset mid-operation: outputs clear immediately (asynchronously); a pending write is discarded.

Decomposition:
- wb_slave_mem_pkg holds:
  - CTI_CLASSIC/CTI_INCR/CTI_EOB constants;
  - BTE_LINEAR/BTE_WRAP4/BTE_WRAP8/BTE_WRAP16 constants;
  - the state enum typedef.
- Sub-module wb_burst_addr_gen: combinational next-word-index from (index, BTE), shared by a future wb slave register block.

Test Plan:
- Classic write 0xDEADBEEF at 0x10 with SEL=4'hF and wait_cycles=0, then read 0x10 -> ACK one cycle after STB each time; read DAT_R=0xDEADBEEF; beat_count=2.
- Byte-lane write 0x000000AA to 0x20 with SEL=4'b0001 over prior 0x11223344 -> read returns 0x112233AA.
- wait_cycles=3 classic read -> ACK rises exactly 4 cycles after STB sampled; lasts one cycle.
- Wrap4 incrementing read starting at word 2 of words 0..3 = 0,1,2,3 (CTI 010,010,010,111) -> DAT_R sequence 2,3,0,1; ACK high 4 consecutive cycles, then 0.
- Read of ADR = 4*2^MEM_DEPTH_LOG2 -> ERR=1 for one cycle, ACK=0; a write to the same address leaves memory unchanged.
- CYC dropped during WAIT with wait_cycles=5, and separately rstn pulsed mid-burst -> no ACK or ERR follows; FSM returns to IDLE; next classic cycle completes normally.
